// File: rtl/adder_bist.sv
// adder_bist: self-test sequencer wrapped around the adder-select block.
// It drives pseudo-random operands into the wrapper, checks the returned
// Sum/Car against a golden model and accumulates pass/fail status. Every
// mode k whose mode_mask bit is set is swept in ascending order. Each mode
// uses the same LFSR sequence, which restarts from SEED at every mode.
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   start, mode_mask       run request pulse; mode enable mask (bit k -> Sel=k)
//   A_o, B_o, Cin_o, Sel_o registered operands and select toward the wrapper
//   Sum_i, Car_i           combinational wrapper result
//   busy, done, pass       run status (pass is only meaningful while done=1)
//   err_count              saturating count of mismatching vectors
//   fail_sel/a/b/cin       vector of the first mismatch of the run
//
// WIDTH must match the wrapper's operand width `N (4..15).
// Optional macro ADDER_BIST_CORNER_EN: each mode first applies 4 directed
// corner vectors before its random ones. The LFSR holds its value while the
// corner vectors are applied.
module adder_bist #(
  parameter int          WIDTH       = 8,
  parameter int          NUM_VECTORS = 256,
  parameter logic [31:0] SEED        = 32'h1234_ABCD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       mode_mask,
  output logic [WIDTH-1:0] A_o,
  output logic [WIDTH-1:0] B_o,
  output logic             Cin_o,
  output logic [2:0]       Sel_o,
  input  logic [WIDTH-1:0] Sum_i,
  input  logic             Car_i,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [15:0]      err_count,
  output logic [2:0]       fail_sel,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic             fail_cin
);

  typedef enum logic [1:0] {IDLE, DRIVE, CHECK, DONE} state_t;

  // An all-zero LFSR would lock up, so a zero seed becomes 1.
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);

  state_t      state, state_nxt;
  logic [31:0] lfsr, lfsr_step;
  logic [3:0]  mask_q;
  logic [1:0]  mode, first_mode, next_mode;
  logic        first_found, next_found;
  logic [15:0] vec_cnt;
  logic        last_vec, mode_end, mismatch;
  logic [4:0]  nib_sum;
  logic [WIDTH:0] golden;

`ifdef ADDER_BIST_CORNER_EN
  localparam logic [31:0] ALT32 = 32'h5555_5555;
  localparam logic [WIDTH-1:0] ALT = ALT32[WIDTH-1:0];
  logic [2:0] corner;  // 0..3 = corner vector index, 4 = random phase
  assign mode_end = last_vec && (corner == 3'd4);
`else
  assign mode_end = last_vec;
`endif

  assign lfsr_step = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
  assign last_vec  = (vec_cnt == LAST_VEC);

  assign busy = (state == DRIVE) || (state == CHECK);
  assign done = (state == DONE);
  assign pass = done && (err_count == 16'h0);

  // Lowest enabled mode of the incoming mask, and the next enabled mode
  // above the current one in the latched mask. The loops scan downward so
  // that the last match (the lowest index) wins.
  always_comb begin
    first_found = 1'b0;
    first_mode  = 2'd0;
    next_found  = 1'b0;
    next_mode   = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (mode_mask[k]) begin
        first_found = 1'b1;
        first_mode  = 2'(k);
      end
      if (mask_q[k] && (k > int'(mode))) begin
        next_found = 1'b1;
        next_mode  = 2'(k);
      end
    end
  end

  // Golden result for the vector currently on the operand outputs. Sel_o
  // always equals mode while in CHECK.
  always_comb begin
    nib_sum = {1'b0, A_o[3:0]} + {1'b0, B_o[3:0]} + {4'b0, Cin_o};
    if (mode == 2'd3)
      golden = {nib_sum[4], {(WIDTH-4){1'b0}}, nib_sum[3:0]};
    else
      golden = {1'b0, A_o} + {1'b0, B_o} + {{WIDTH{1'b0}}, Cin_o};
    mismatch = ({Car_i, Sum_i} != golden);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = first_found ? DRIVE : DONE;
      DRIVE:      state_nxt = CHECK;
      CHECK:      state_nxt = (mode_end && !next_found) ? DONE : DRIVE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr      <= SEED_EFF;
      mask_q    <= 4'h0;
      mode      <= 2'd0;
      vec_cnt   <= 16'h0;
      A_o       <= '0;
      B_o       <= '0;
      Cin_o     <= 1'b0;
      Sel_o     <= 3'd0;
      err_count <= 16'h0;
      fail_sel  <= 3'd0;
      fail_a    <= '0;
      fail_b    <= '0;
      fail_cin  <= 1'b0;
`ifdef ADDER_BIST_CORNER_EN
      corner    <= 3'd0;
`endif
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          mask_q    <= mode_mask;
          mode      <= first_mode;
          vec_cnt   <= 16'h0;
          lfsr      <= SEED_EFF;
          err_count <= 16'h0;
          fail_sel  <= 3'd0;
          fail_a    <= '0;
          fail_b    <= '0;
          fail_cin  <= 1'b0;
`ifdef ADDER_BIST_CORNER_EN
          corner    <= 3'd0;
`endif
        end
        DRIVE: begin
          Sel_o <= {1'b0, mode};
`ifdef ADDER_BIST_CORNER_EN
          if (corner != 3'd4) begin
            case (corner)
              3'd0:    begin A_o <= '0;   B_o <= '0;   Cin_o <= 1'b0; end
              3'd1:    begin A_o <= '1;   B_o <= '0;   Cin_o <= 1'b1; end
              3'd2:    begin A_o <= '1;   B_o <= '1;   Cin_o <= 1'b1; end
              default: begin A_o <= ALT;  B_o <= ~ALT; Cin_o <= 1'b0; end
            endcase
          end else
`endif
          begin
            A_o   <= lfsr[WIDTH-1:0];
            B_o   <= lfsr[2*WIDTH-1:WIDTH];
            Cin_o <= lfsr[31];
          end
        end
        CHECK: begin
          if (mismatch) begin
            if (err_count != 16'hFFFF) err_count <= err_count + 16'h1;
            // A zero count can only mean no mismatch has been seen yet.
            if (err_count == 16'h0) begin
              fail_sel <= Sel_o;
              fail_a   <= A_o;
              fail_b   <= B_o;
              fail_cin <= Cin_o;
            end
          end
`ifdef ADDER_BIST_CORNER_EN
          if (corner != 3'd4) corner <= corner + 3'd1;
          else
`endif
          if (last_vec) begin
            vec_cnt <= 16'h0;
            if (next_found) begin
              mode <= next_mode;
              lfsr <= SEED_EFF;
`ifdef ADDER_BIST_CORNER_EN
              corner <= 3'd0;
`endif
            end else begin
              lfsr <= lfsr_step;
            end
          end else begin
            vec_cnt <= vec_cnt + 16'h1;
            lfsr    <= lfsr_step;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/adder_bist.md
Name: adder_bist

Overview:
- Self-test sequencer that sits on both sides of the adder-select wrapper.
- Upstream, it drives operands A/B/Cin and Sel into the wrapper.
- Downstream, it consumes Sum/Car, compares them against an internal golden model, and accumulates pass/fail status.
- Used in simulation and on silicon to sweep every enabled adder mode with identical pseudo-random vectors.

Parameters:
- WIDTH, 8, operand width; must equal `N; legal range 4..15.
- NUM_VECTORS, 256, random vectors applied per enabled mode; legal range 1..65535.
- SEED, 32'h1234_ABCD, LFSR reload value; a value of 0 is replaced by 32'h1.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  single-cycle pulse; begins a run
- mode_mask  input  4  bit k=1 enables testing of Sel=k (k=0..3); sampled on accepted start
- A_o  output  WIDTH  operand A to wrapper
- B_o  output  WIDTH  operand B to wrapper
- Cin_o  output  1  carry-in to wrapper
- Sel_o  output  3  adder select to wrapper
- Sum_i  input  WIDTH  wrapper sum
- Car_i  input  1  wrapper carry-out
- busy  output  1  run in progress
- done  output  1  run finished; held until next accepted start or rst
- pass  output  1  meaningful only while done=1; 1 when err_count==0
- err_count  output  16  mismatching vectors; saturates at 16'hFFFF
- fail_sel  output  3  Sel of the first mismatch
- fail_a  output  WIDTH  A of the first mismatch
- fail_b  output  WIDTH  B of the first mismatch
- fail_cin  output  1  Cin of the first mismatch

Behaviour:
- Reset:
  - Every output is 0.
  - FSM goes to IDLE, the LFSR is loaded with SEED, and the first-fail capture is cleared.
  - rst mid-run aborts the run immediately with the same values.
- FSM states are IDLE, DRIVE, CHECK, DONE.
- IDLE, or DONE, with start=1:
  - Latch mode_mask; clear err_count and fail_*; done=0.
  - Pick the lowest enabled mode, load the LFSR with SEED, busy=1, go to DRIVE.
  - If the mask is 0: go directly to DONE with pass=1 and busy=0.
- start while busy is ignored.
- DRIVE (1 cycle):
  - A_o, B_o, Cin_o, Sel_o are registered outputs updated in this cycle.
  - A_o=lfsr[WIDTH-1:0], B_o=lfsr[2*WIDTH-1:WIDTH], Cin_o=lfsr[31], Sel_o=current mode.
- CHECK (1 cycle): Sum_i/Car_i are sampled. The wrapper is combinational, so there is zero added latency.
  - Golden model for Sel 0, 1, 2: {Car,Sum} = A + B + Cin, computed WIDTH+1 bits wide.
  - Golden model for Sel 3: t = A[3:0] + B[3:0] + Cin (5 bits). Sum = {(WIDTH-4) zeros, t[3:0]}, Car = t[4].
  - On mismatch: err_count++ (saturating). If this is the first mismatch of the run, capture fail_sel/a/b/cin.
  - Then advance the LFSR: next = {lfsr[30:0], lfsr[31]^lfsr[21]^lfsr[1]^lfsr[0]}.
  - If this was not the last vector of the mode: go to DRIVE.
  - If it was the last vector: move to the next enabled mode, reload the LFSR with SEED, and go to DRIVE.
  - If no enabled mode remains: go to DONE.
- DONE: busy=0, done=1, pass=(err_count==0). Operand outputs hold their last values.
- Timing: with M enabled modes, done is visible after edge t0 + 2·NUM_VECTORS·M, where t0 is the edge that sampled start.
- Mode order is ascending Sel. Sel values 4..7 are never driven.
- Vector counter is 16 bits and wraps only at NUM_VECTORS.

Optional Feature:
- Macro: ADDER_BIST_CORNER_EN.
- When defined, each enabled mode first applies 4 directed vectors before its NUM_VECTORS random ones:
  - (0, 0, 0)
  - (all-ones, 0, 1)
  - (all-ones, all-ones, 1)
  - (0x55.., 0xAA.., 0)
- Each corner vector uses a DRIVE/CHECK pair, and the LFSR is not advanced during them.
- With the feature, the done timing becomes t0 + 2·(NUM_VECTORS+4)·M.
- When not defined, only LFSR vectors are applied, and there is no corner logic or counter state.

Test Plan:
1. Assert rst for 2 cycles with WIDTH=8 → all outputs 0, busy=0, done=0. Pulse start with mask=0 → done=1 and pass=1 after 1 edge, err_count=0.
2. NUM_VECTORS=4, mask=4'b0001, correct wrapper:
   - busy=1 for exactly 8 cycles, then done=1, pass=1, err_count=0.
   - A_o/B_o in the first DRIVE = SEED[7:0]=8'hCD and SEED[15:8]=8'hAB.
3. NUM_VECTORS=4, mask=4'b0111, wrapper model returns Sum+1 for Sel=2 only → done after 24 cycles, err_count=4, pass=0, fail_sel=2, fail_a=8'hCD, fail_b=8'hAB, fail_cin=SEED[31]=0.
4. Sel=3 mode, model drives Sum[7:4]=4'h1 → every vector mismatches, err_count=NUM_VECTORS. Correct model (upper nibble 0) → pass=1.
5. Assert rst at cycle 5 of a run → next cycle busy=0, done=0, err_count=0. A later start reruns from SEED.
6. Pulse start again while busy → ignored, and done timing is unchanged. With ADDER_BIST_CORNER_EN and NUM_VECTORS=1, mask=4'b0001 → first DRIVE has A=0, B=0, Cin=0, and done comes after 10 cycles.
